// File: rtl/enc64_seq.sv
// Sequential 2^W-to-W encoder: captures a request vector and streams the index of
// every set bit over a valid/ready handshake, in lowest- or highest-first order.
module enc64_seq #(
    parameter int W        = 6,
    parameter bit PRI_HIGH = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [2**W-1:0]   req,
    output logic              busy,
    output logic              valid,
    output logic [W-1:0]      o,
    input  logic              ready,
    output logic [W:0]        cnt,
    output logic              done
);

    localparam int N = 2**W;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state_reg;
    logic [N-1:0]     pend_reg;
    logic             busy_reg;
    logic             valid_reg;
    logic [W-1:0]     o_reg;
    logic [W:0]       cnt_reg;
    logic             done_reg;

    logic [N-1:0]     pend_clr;
    logic [N-1:0]     enc_in;
    logic [N-1:0]     enc_vec;
    logic [W-1:0]     enc_low;
    logic [W-1:0]     enc_idx;
    logic [W:0]       cnt_load;
    logic             handshake;
    logic             last_beat;

    // Pending vector with the index currently on o removed.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_clr
            assign pend_clr[gi] = pend_reg[gi] & (o_reg != W'(gi));
        end
    endgenerate

    // The encoder always looks at the value pend takes next, so o is registered
    // straight from it and ready never reaches o combinationally.
    assign enc_in = (state_reg == IDLE) ? req : pend_clr;

    // High-first priority is handled by bit-reversing into a low-first encoder.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_order
            if (PRI_HIGH) begin : g_rev
                assign enc_vec[gi] = enc_in[N-1-gi];
            end else begin : g_fwd
                assign enc_vec[gi] = enc_in[gi];
            end
        end
    endgenerate

    always_comb begin
        enc_low = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (enc_vec[i]) begin
                enc_low = W'(i);
            end
        end
    end

    generate
        if (PRI_HIGH) begin : g_idx_rev
            assign enc_idx = W'(N - 1) - enc_low;
        end else begin : g_idx_fwd
            assign enc_idx = enc_low;
        end
    endgenerate

    always_comb begin
        cnt_load = '0;
        for (int i = 0; i < N; i++) begin
            cnt_load = cnt_load + (W+1)'(req[i]);
        end
    end

    assign handshake = valid_reg & ready;
    assign last_beat = (cnt_reg == (W+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            pend_reg  <= '0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            o_reg     <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        if (req != '0) begin
                            state_reg <= EMIT;
                            pend_reg  <= req;
                            busy_reg  <= 1'b1;
                            valid_reg <= 1'b1;
                            o_reg     <= enc_idx;
                            cnt_reg   <= cnt_load;
                        end else begin
                            done_reg  <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        if (last_beat) begin
                            state_reg <= IDLE;
                            pend_reg  <= '0;
                            busy_reg  <= 1'b0;
                            valid_reg <= 1'b0;
                            cnt_reg   <= '0;
                            done_reg  <= 1'b1;
                        end else begin
                            pend_reg  <= pend_clr;
                            o_reg     <= enc_idx;
                            cnt_reg   <= cnt_reg - (W+1)'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_reg;
    assign valid = valid_reg;
    assign o     = o_reg;
    assign cnt   = cnt_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_enc64_seq.sv
// Directed bench for enc64_seq: one low-first and one high-first instance share
// the same stimulus; every step checks registered outputs against hand values.
module tb_enc64_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [63:0] req;
    logic        ready;

    logic        busy_lo, valid_lo, done_lo;
    logic [5:0]  o_lo;
    logic [6:0]  cnt_lo;
    logic        busy_hi, valid_hi, done_hi;
    logic [5:0]  o_hi;
    logic [6:0]  cnt_hi;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [63:0] SPARSE = (64'd1 << 3) | (64'd1 << 17) | (64'd1 << 63);

    enc64_seq #(.W(6), .PRI_HIGH(1'b0)) dut_lo (
        .clk(clk), .rst(rst), .load(load), .req(req),
        .busy(busy_lo), .valid(valid_lo), .o(o_lo), .ready(ready),
        .cnt(cnt_lo), .done(done_lo)
    );

    enc64_seq #(.W(6), .PRI_HIGH(1'b1)) dut_hi (
        .clk(clk), .rst(rst), .load(load), .req(req),
        .busy(busy_hi), .valid(valid_hi), .o(o_hi), .ready(ready),
        .cnt(cnt_hi), .done(done_hi)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_lo(input string tag, input logic b, input logic v,
                            input logic [5:0] oo, input logic [6:0] c, input logic d);
        check({tag, ".busy"},  64'(busy_lo),  64'(b));
        check({tag, ".valid"}, 64'(valid_lo), 64'(v));
        check({tag, ".o"},     64'(o_lo),     64'(oo));
        check({tag, ".cnt"},   64'(cnt_lo),   64'(c));
        check({tag, ".done"},  64'(done_lo),  64'(d));
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; req = '0; ready = 1'b0;
        tick(); tick();
        check_lo("reset", 1'b0, 1'b0, 6'd0, 7'd0, 1'b0);
        check("reset.hi_valid", 64'(valid_hi), 64'd0);
        rst = 1'b0;
        tick();

        // Empty load
        load = 1'b1; req = '0;
        tick();
        load = 1'b0;
        check_lo("empty", 1'b0, 1'b0, 6'd0, 7'd0, 1'b1);
        tick();
        check_lo("empty_after", 1'b0, 1'b0, 6'd0, 7'd0, 1'b0);

        // Sparse burst at full throughput
        load = 1'b1; req = SPARSE; ready = 1'b1;
        tick();
        load = 1'b0;
        check_lo("sparse0", 1'b1, 1'b1, 6'd3, 7'd3, 1'b0);
        check("sparse0.hi_o", 64'(o_hi), 64'd63);
        tick();
        check_lo("sparse1", 1'b1, 1'b1, 6'd17, 7'd2, 1'b0);
        check("sparse1.hi_o", 64'(o_hi), 64'd17);
        tick();
        check_lo("sparse2", 1'b1, 1'b1, 6'd63, 7'd1, 1'b0);
        check("sparse2.hi_o", 64'(o_hi), 64'd3);
        tick();
        check_lo("sparse_end", 1'b0, 1'b0, 6'd63, 7'd0, 1'b1);
        check("sparse_end.hi_o", 64'(o_hi), 64'd3);
        check("sparse_end.hi_done", 64'(done_hi), 64'd1);
        tick();
        check("sparse_post.done", 64'(done_lo), 64'd0);

        // Backpressure for four cycles
        ready = 1'b0; load = 1'b1; req = SPARSE;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_lo($sformatf("bp_hold%0d", k), 1'b1, 1'b1, 6'd3, 7'd3, 1'b0);
            if (k < 3) tick();
        end
        ready = 1'b1;
        tick();
        check_lo("bp1", 1'b1, 1'b1, 6'd17, 7'd2, 1'b0);
        tick();
        check_lo("bp2", 1'b1, 1'b1, 6'd63, 7'd1, 1'b0);
        tick();
        check_lo("bp_end", 1'b0, 1'b0, 6'd63, 7'd0, 1'b1);
        tick();

        // Full vector
        load = 1'b1; req = '1; ready = 1'b1;
        tick();
        load = 1'b0;
        check("full.cnt0", 64'(cnt_lo), 64'd64);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("full%0d.o", i), 64'(o_lo), 64'(i));
            check($sformatf("full%0d.cnt", i), 64'(cnt_lo), 64'(64 - i));
            check($sformatf("full%0d.hi_o", i), 64'(o_hi), 64'(63 - i));
            tick();
        end
        check_lo("full_end", 1'b0, 1'b0, 6'd63, 7'd0, 1'b1);
        tick();

        // LOAD while busy is ignored
        load = 1'b1; req = SPARSE;
        tick();
        check_lo("intf0", 1'b1, 1'b1, 6'd3, 7'd3, 1'b0);
        req = '1;
        tick();
        load = 1'b0;
        check_lo("intf1", 1'b1, 1'b1, 6'd17, 7'd2, 1'b0);
        tick();
        check_lo("intf2", 1'b1, 1'b1, 6'd63, 7'd1, 1'b0);
        tick();
        check_lo("intf_end", 1'b0, 1'b0, 6'd63, 7'd0, 1'b1);
        tick();

        // Reset aborts a burst after the second handshake
        load = 1'b1; req = SPARSE;
        tick();
        load = 1'b0;
        check_lo("abort0", 1'b1, 1'b1, 6'd3, 7'd3, 1'b0);
        tick();
        tick();
        check_lo("abort2", 1'b1, 1'b1, 6'd63, 7'd1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_lo("abort_rst", 1'b0, 1'b0, 6'd0, 7'd0, 1'b0);
        tick();
        check("abort_post.done", 64'(done_lo), 64'd0);

        // Fresh load after reset
        load = 1'b1; req = 64'd1 << 5;
        tick();
        load = 1'b0;
        check_lo("fresh0", 1'b1, 1'b1, 6'd5, 7'd1, 1'b0);
        tick();
        check_lo("fresh_end", 1'b0, 1'b0, 6'd5, 7'd0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
